xmuladd_pipe: RTL

- Parametrised successor to the Versat multiply-accumulate functional unit: signed MAC/MSUB/MUL datapath with a 3-stage pipeline and a guard-bit accumulator.
- Has its own internal period/iteration sequencer, so no external address generator is needed.
- Output stage adds round-to-nearest, arithmetic shift and optional saturation, plus valid/done/busy handshakes.
- Sits in the data engine between the flow_in bus and flow_out, driven by the controller through the config ports.

---
 rtl/xmuladd_pipe.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/xmuladd_pipe.sv
// xmuladd_pipe: signed multiply-accumulate unit with its own period/iteration
// sequencer, a 3-stage arithmetic pipeline feeding a guard-bit accumulator,
// and an output stage with round-half-up, arithmetic shift and saturation.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   run                 start pulse, sampled only when idle
//   flow_in             N_SRC sources of DATA_W bits; source i = [i*DATA_W +: DATA_W]
//   sela, selb          operand A / B source index
//   opcode              00 MACC, 01 MSUB, 10 MUL, 11 MACC
//   iterations          number of accumulation periods (0 = run ignored)
//   period              samples per period (0 acts as 1)
//   delay               idle cycles between run acceptance and first sample
//   shift               arithmetic right shift applied at the output
//   rnd_en, sat_en      round-half-up before shift; saturate to signed DATA_W
//   flow_out            registered result, held until the next valid_out
//   valid_out           one-cycle pulse per new result
//   done                one-cycle pulse with the last result of a run
//   busy                high from run acceptance until the cycle after done
//   ovf                 sticky out-of-range flag, cleared on run acceptance
module xmuladd_pipe #(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 72,
  parameter int N_SRC   = 16,
  parameter int SEL_W   = 4,
  parameter int ITER_W  = 10,
  parameter int PER_W   = 6,
  parameter int SHIFT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [N_SRC*DATA_W-1:0] flow_in,
  input  logic [SEL_W-1:0]        sela,
  input  logic [SEL_W-1:0]        selb,
  input  logic [1:0]              opcode,
  input  logic [ITER_W-1:0]       iterations,
  input  logic [PER_W-1:0]        period,
  input  logic [PER_W-1:0]        delay,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic                    rnd_en,
  input  logic                    sat_en,
  output logic [DATA_W-1:0]       flow_out,
  output logic                    valid_out,
  output logic                    done,
  output logic                    busy,
  output logic                    ovf
);

  // One extra bit above the accumulator so the rounding add cannot wrap.
  localparam int OW = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  // Shadow configuration, captured when run is accepted.
  logic [SEL_W-1:0]   r_sela, r_selb;
  logic               r_sub, r_mul;
  logic [PER_W-1:0]   r_per_m1;
  logic [ITER_W-1:0]  r_iter_m1;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_rnd, r_sat;

  // Sequencer counters.
  logic [PER_W-1:0]   r_cnt;
  logic [PER_W-1:0]   r_p;
  logic [ITER_W-1:0]  r_it;
  logic [1:0]         r_drain;

  // Pipeline: stage 1 operands, stage 2 product, stage 3 accumulator.
  logic signed [DATA_W-1:0]   w_a, w_b, r_a, r_b;
  logic signed [2*DATA_W-1:0] r_prod;
  logic signed [ACC_W-1:0]    r_acc, w_p_ext, w_base, w_acc_nxt;
  logic r_v1, r_f1, r_l1, r_v2, r_f2, r_l2, r_v3;

  // Output stage.
  logic signed [OW-1:0]   w_rnd, w_v, w_r;
  logic [OW-DATA_W:0]     w_top;
  logic                   w_in_range;
  logic [DATA_W-1:0]      w_res;
  logic [DATA_W-1:0]      r_flow;
  logic                   r_valid, r_done, r_busy, r_ovf;

  logic w_accept, w_sample, w_per_end, w_last;

  // busy stays high through the cycle after the final DRAIN cycle, so a
  // new run is only accepted once both the FSM and busy are back to idle.
  assign w_accept  = (r_state == S_IDLE) && !r_busy && run && (iterations != '0);
  assign w_sample  = (r_state == S_RUN);
  assign w_per_end = (r_p == r_per_m1);
  assign w_last    = w_sample && w_per_end && (r_it == r_iter_m1);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves the
    // signal unassigned, which would infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (delay != '0) ? S_DELAY : S_RUN;
      S_DELAY: if (r_cnt == PER_W'(1)) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain == 2'd2) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------- shadow configuration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sela    <= '0;
      r_selb    <= '0;
      r_sub     <= 1'b0;
      r_mul     <= 1'b0;
      r_per_m1  <= '0;
      r_iter_m1 <= '0;
      r_shift   <= '0;
      r_rnd     <= 1'b0;
      r_sat     <= 1'b0;
    end else if (w_accept) begin
      r_sela    <= sela;
      r_selb    <= selb;
      r_sub     <= (opcode == 2'b01);
      r_mul     <= (opcode == 2'b10);
      r_per_m1  <= (period == '0) ? '0 : period - PER_W'(1);
      r_iter_m1 <= iterations - ITER_W'(1);
      r_shift   <= shift;
      r_rnd     <= rnd_en;
      r_sat     <= sat_en;
    end
  end

  // ------------------------------------------------------ counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_it    <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt   <= delay;
          r_p     <= '0;
          r_it    <= '0;
          r_drain <= '0;
        end
        S_DELAY: r_cnt <= r_cnt - PER_W'(1);
        S_RUN: begin
          if (w_per_end) begin
            r_p  <= '0;
            r_it <= r_it + ITER_W'(1);
          end else begin
            r_p  <= r_p + PER_W'(1);
          end
        end
        S_DRAIN: r_drain <= r_drain + 2'd1;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------- operand select
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_sela == SEL_W'(i)) w_a = flow_in[i*DATA_W +: DATA_W];
      if (r_selb == SEL_W'(i)) w_b = flow_in[i*DATA_W +: DATA_W];
    end
  end

  // ------------------------------------------------- accumulate logic
  always_comb begin
    w_p_ext   = ACC_W'(r_prod);
    // First sample of a period restarts the sum instead of adding to it.
    w_base    = r_f2 ? '0 : r_acc;
    w_acc_nxt = r_sub ? (w_base - w_p_ext) : (w_base + w_p_ext);
  end

  // --------------------------------------------------- output stage
  always_comb begin
    w_rnd = '0;
    if (r_rnd && (r_shift != '0)) w_rnd = OW'(1) << (r_shift - SHIFT_W'(1));
    w_v = OW'(r_acc) + w_rnd;
    if (int'(r_shift) >= OW) w_r = {OW{w_v[OW-1]}};
    else                     w_r = w_v >>> r_shift;
    // In range for signed DATA_W when every bit above the DATA_W sign bit
    // matches it.
    w_top      = w_r[OW-1:DATA_W-1];
    w_in_range = (&w_top) || !(|w_top);
    w_res      = w_r[DATA_W-1:0];
    if (r_sat && !w_in_range)
      w_res = w_r[OW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // ------------------------------------------------------- pipeline
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the accumulator and pipeline registers are reset because a reset
    // must discard in-flight results and leave the sum at zero.
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_v1    <= 1'b0;
      r_f1    <= 1'b0;
      r_l1    <= 1'b0;
      r_prod  <= '0;
      r_v2    <= 1'b0;
      r_f2    <= 1'b0;
      r_l2    <= 1'b0;
      r_acc   <= '0;
      r_v3    <= 1'b0;
      r_flow  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // MUL treats every sample as both first and last of its own period.
      r_a    <= w_a;
      r_b    <= w_b;
      r_v1   <= w_sample;
      r_f1   <= w_sample && (r_mul || (r_p == '0));
      r_l1   <= w_sample && (r_mul || w_per_end);

      r_prod <= (2*DATA_W)'(r_a) * (2*DATA_W)'(r_b);
      r_v2   <= r_v1;
      r_f2   <= r_f1;
      r_l2   <= r_l1;

      if (r_v2) r_acc <= w_acc_nxt;
      r_v3   <= r_v2 && r_l2;

      r_valid <= r_v3;
      if (r_v3) r_flow <= w_res;

      if (w_accept)                 r_ovf <= 1'b0;
      if (r_v3 && !w_in_range)      r_ovf <= 1'b1;

      // Last result leaves the output register on the edge that ends DRAIN.
      r_done <= (r_state == S_DRAIN) && (r_drain == 2'd2);
      if (w_accept)    r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
    end
  end

  assign flow_out  = r_flow;
  assign valid_out = r_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign ovf       = r_ovf;

endmodule
